inst_fetch_queue: RTL and testbench

- Sits between the IF stage (pc / inst_addr generator) and the ID stage.
- Tracks each fetch address presented to the synchronous instruction memory and pairs it with the returned instruction one cycle later.
- Buffers {pc, inst} pairs in a small FIFO and hands them to ID through a valid/ready handshake.
- Drives if_stall back to IF for backpressure, and discards wrong-path fetches on jmp / jmp_from_ex.

---
 rtl/inst_fetch_queue_pkg.sv | 23 ++
 rtl/inst_fetch_queue_sync_fifo_flush.sv | 70 +++++++
 rtl/inst_fetch_queue.sv | 84 ++++++++
 tb/tb_inst_fetch_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared IF/ID pipeline definitions for the fetch queue.
// Rev 1.0
`default_nettype none

package inst_fetch_queue_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- what ID sees whenever the queue has nothing to offer
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_sync_fifo_flush.sv
// sync_fifo_flush: DEPTH x W synchronous FIFO with a single-cycle flush.
// Rev 1.0
`default_nettype none

module sync_fifo_flush #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: pairs fetch addresses with next-cycle memory data and queues them for ID.
// Rev 1.0
`default_nettype none

module inst_fetch_queue #(
  parameter int              XLEN     = inst_fetch_queue_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP_INST = inst_fetch_queue_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic [XLEN-1:0] inst_addr,
  input  logic [XLEN-1:0] inst_rdata,
  input  logic            jmp,
  input  logic            jmp_from_ex,
  output logic            if_stall,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst
);

  import inst_fetch_queue_pkg::*;

  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

  logic            flush;
  logic            accept;
  logic            push;
  logic            pop;
  logic            req_v;
  logic [XLEN-1:0] req_pc;
  logic [2*XLEN-1:0] head;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;

  assign flush = jmp | jmp_from_ex;

  // count + req_v >= DEPTH, built from registers only so ID never reaches IF combinationally
  assign if_stall = full | (req_v & (count == LAST_SLOT));

  assign accept = ce & ~if_stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_v  <= 1'b0;
      req_pc <= '0;
    end else begin
      req_v <= accept;
      if (accept) begin
        req_pc <= inst_addr;
      end
    end
  end

  assign push = req_v & ~flush;
  assign pop  = id_valid & id_ready;

  sync_fifo_flush #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({req_pc, inst_rdata}),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign id_valid = ~empty & ~flush;
  assign id_pc    = id_valid ? head[2*XLEN-1:XLEN] : '0;
  assign id_inst  = id_valid ? head[XLEN-1:0]      : NOP_INST;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for inst_fetch_queue.
`default_nettype none

module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        jmp;
  logic        jmp_from_ex;
  logic        id_ready;
  logic        if_stall;
  logic        id_valid;
  logic [31:0] addr;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;
  int exp_pc;
  int steady;

  always #5 clk = ~clk;

  assign inst_addr = addr;

  // Synchronous instruction memory: word at address a reads back as a + 0x100
  always @(posedge clk) inst_rdata <= inst_addr + 32'h100;

  inst_fetch_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .jmp         (jmp),
    .jmp_from_ex (jmp_from_ex),
    .if_stall    (if_stall),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_inst     (id_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic j, input logic jx);
    ce          = c;
    id_ready    = r;
    jmp         = j;
    jmp_from_ex = jx;
    #2;
  endtask

  // IF model: advance the fetch address only when the queue took it
  task automatic tick();
    logic acc;
    acc = ce & ~if_stall & ~jmp & ~jmp_from_ex;
    @(posedge clk);
    #1;
    if (acc) addr = addr + 32'd4;
  endtask

  task automatic chk_pop();
    if (id_valid) begin
      chk("stream_pc", id_pc, exp_pc);
      chk("stream_inst", id_inst, exp_pc + 32'h100);
      if (id_ready) exp_pc += 4;
    end
  endtask

  task automatic flush_case(input logic j, input logic jx);
    addr = 32'h0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, j, jx);
    chk("flush_cycle_valid", id_valid, 1'b0);
    chk("flush_cycle_inst", id_inst, 32'h13);
    tick();
    addr = 32'h200;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_flush_valid", id_valid, 1'b0);
    chk("post_flush_inst", id_inst, 32'h13);
    chk("post_flush_stall", if_stall, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_flush_valid2", id_valid, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("redirect_valid0", id_valid, 1'b1);
    chk("redirect_pc0", id_pc, 32'h200);
    chk("redirect_inst0", id_inst, 32'h300);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("redirect_pc1", id_pc, 32'h204);
    chk("redirect_inst1", id_inst, 32'h304);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("inflight_dropped", id_valid, 1'b0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = 32'h0;
    ce = 1'b0; jmp = 1'b0; jmp_from_ex = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_stall", if_stall, 1'b0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h13);
    rst_n = 1'b1;

    // Streaming: 0,4,8,12 emerge one per cycle starting two cycles after the first fetch
    for (int k = 0; k < 7; k++) begin
      drive(k < 4, 1'b1, 1'b0, 1'b0);
      chk("s_stall", if_stall, 1'b0);
      if (k >= 2 && k <= 5) begin
        chk("s_valid", id_valid, 1'b1);
        chk("s_pc", id_pc, 32'((k - 2) * 4));
        chk("s_inst", id_inst, 32'(32'h100 + (k - 2) * 4));
      end else begin
        chk("s_idle", id_valid, 1'b0);
      end
      tick();
    end

    // Backpressure: fill to four, hold 16, then drain in order
    addr = 32'h0;
    drive(1, 0, 0, 0); chk("bp_c0_stall", if_stall, 0); chk("bp_c0_valid", id_valid, 0); tick();
    drive(1, 0, 0, 0); chk("bp_c1_stall", if_stall, 0); tick();
    drive(1, 0, 0, 0); chk("bp_c2_stall", if_stall, 0); chk("bp_c2_pc", id_pc, 32'h0); tick();
    drive(1, 0, 0, 0); chk("bp_c3_stall", if_stall, 0); tick();
    drive(1, 0, 0, 0); chk("bp_c4_stall", if_stall, 1); tick();
    drive(1, 0, 0, 0); chk("bp_c5_stall", if_stall, 1); chk("bp_c5_pc", id_pc, 32'h0); tick();
    drive(1, 1, 0, 0); chk("bp_pop_same_cycle_stall", if_stall, 1); chk("bp_c6_pc", id_pc, 32'h0); tick();
    drive(1, 1, 0, 0); chk("bp_stall_release", if_stall, 0); chk("bp_c7_pc", id_pc, 32'h4); tick();
    drive(0, 1, 0, 0); chk("bp_c8_pc", id_pc, 32'h8); tick();
    drive(0, 1, 0, 0); chk("bp_c9_pc", id_pc, 32'hC); tick();
    drive(0, 1, 0, 0); chk("bp_c10_pc", id_pc, 32'h10); chk("bp_c10_inst", id_inst, 32'h110); tick();
    drive(0, 1, 0, 0); chk("bp_no_duplicate", id_valid, 0); tick();

    // Near-full push+pop and pointer wrap over several laps
    addr   = 32'h0;
    exp_pc = 0;
    steady = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap_stall_count3_inflight", if_stall, 1'b1);
    chk_pop();
    tick();
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (i >= 4 && id_valid) steady++;
      chk_pop();
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk_pop();
      tick();
    end
    chk("wrap_all_delivered", 32'(exp_pc), addr);
    chk("wrap_throughput", 32'(steady), 32'd15);

    flush_case(1'b1, 1'b0);
    flush_case(1'b0, 1'b1);
    flush_case(1'b1, 1'b1);

    // Asynchronous reset with two entries queued and one in flight
    addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_valid", id_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", id_valid, 1'b0);
    chk("mid_rst_stall", if_stall, 1'b0);
    chk("mid_rst_pc", id_pc, 32'h0);
    chk("mid_rst_inst", id_inst, 32'h13);
    tick();
    rst_n = 1'b1;
    addr  = 32'h0;
    drive(1, 1, 0, 0); chk("rr_c0_valid", id_valid, 0); tick();
    drive(1, 1, 0, 0); chk("rr_c1_valid", id_valid, 0); tick();
    drive(0, 1, 0, 0); chk("rr_pc0", id_pc, 32'h0); chk("rr_inst0", id_inst, 32'h100); tick();
    drive(0, 1, 0, 0); chk("rr_pc1", id_pc, 32'h4); tick();
    drive(0, 1, 0, 0); chk("rr_empty", id_valid, 0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
